// File: rtl/mdio_slave_responder.sv
// mdio_slave_responder: IEEE 802.3 Clause 22 MDIO management target.
// MDC/MDIO are oversampled in the CLK_I domain. A matching frame issues one
// register strobe to a local register file. Read frames also drive the
// turnaround zero and the read data back onto MDIO.
module mdio_slave_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd18,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter bit          BCAST_EN     = 1'b0
) (
  input  logic        CLK_I,
  input  logic        RSTBP_I,
  input  logic        MGMT_MDC_I,
  input  logic        MGMT_MDI_I,
  output logic        MGMT_MDO_O,
  output logic        MGMT_MDOEN_O,
  output logic [4:0]  REG_ADDR_O,
  output logic [15:0] REG_WDATA_O,
  output logic        REG_WE_O,
  output logic        REG_RE_O,
  input  logic [15:0] REG_RDATA_I,
  output logic        BUSY_O
);

  typedef enum logic [3:0] {
    S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA_W, S_DATA_R, S_DONE
  } state_t;

  // The preamble counter saturates at 32, so a larger threshold could never be met.
  localparam logic [5:0] PRE_MAX = 6'd32;
  localparam logic [5:0] PRE_THR = (PREAMBLE_LEN > 32) ? 6'd32 : 6'(PREAMBLE_LEN);

  logic        r_mdc_meta, r_mdc_sync, r_mdc_prev;
  logic        r_mdi_meta, r_mdi_sync;
  logic        w_mdc_rise, w_bit, w_pre_ok, w_match_now;
  logic [4:0]  w_field;
  logic [1:0]  w_op;

  state_t      r_state;
  logic [5:0]  r_pre_cnt;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_shift, r_rdata, r_wdata;
  logic [4:0]  r_addr;
  logic        r_is_read, r_match, r_we, r_re, r_re_d, r_mdo, r_oen, r_busy;

  assign w_mdc_rise  = r_mdc_sync & ~r_mdc_prev;
  assign w_bit       = r_mdi_sync;
  // Field value that includes the bit being sampled now (5-bit fields, MSB first).
  assign w_field     = {r_shift[3:0], w_bit};
  assign w_op        = {r_shift[0], w_bit};
  assign w_pre_ok    = (r_pre_cnt >= PRE_THR);
  // The address match is evaluated as the last PHYAD bit arrives. Broadcast applies only to writes.
  assign w_match_now = (w_field == PHY_ADDR) ||
                       (BCAST_EN && !r_is_read && (w_field == 5'd0));

  assign MGMT_MDO_O   = r_mdo;
  assign MGMT_MDOEN_O = r_oen;
  assign REG_ADDR_O   = r_addr;
  assign REG_WDATA_O  = r_wdata;
  assign REG_WE_O     = r_we;
  assign REG_RE_O     = r_re;
  assign BUSY_O       = r_busy;

  // Two-flop synchronizers for MDC and MDIO, plus the previous MDC value used for rise detection.
  always_ff @(posedge CLK_I or posedge RSTBP_I) begin
    if (RSTBP_I) begin
      r_mdc_meta <= 1'b0;
      r_mdc_sync <= 1'b0;
      r_mdc_prev <= 1'b0;
      r_mdi_meta <= 1'b0;
      r_mdi_sync <= 1'b0;
    end else begin
      r_mdc_meta <= MGMT_MDC_I;
      r_mdc_sync <= r_mdc_meta;
      r_mdc_prev <= r_mdc_sync;
      r_mdi_meta <= MGMT_MDI_I;
      r_mdi_sync <= r_mdi_meta;
    end
  end

  // Frame decoder FSM. All bits are sampled on MDC rise. Strobes and MDIO drive are registered.
  always_ff @(posedge CLK_I or posedge RSTBP_I) begin
    if (RSTBP_I) begin
      r_state   <= S_IDLE;
      r_pre_cnt <= 6'd0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 16'd0;
      r_rdata   <= 16'd0;
      r_wdata   <= 16'd0;
      r_addr    <= 5'd0;
      r_is_read <= 1'b0;
      r_match   <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_re_d    <= 1'b0;
      r_mdo     <= 1'b0;
      r_oen     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_re_d <= r_re;
      // Read data from the register file is valid one cycle after the read strobe.
      if (r_re_d) r_rdata <= REG_RDATA_I;
      case (r_state)
        S_IDLE: if (w_mdc_rise) begin
          if (w_bit) begin
            if (r_pre_cnt != PRE_MAX) r_pre_cnt <= r_pre_cnt + 6'd1;
          end else if (w_pre_ok) begin
            r_state   <= S_ST1;
            r_busy    <= 1'b1;
            r_pre_cnt <= 6'd0;
          end else begin
            r_pre_cnt <= 6'd0;
          end
        end
        S_ST1: if (w_mdc_rise) begin
          if (w_bit) begin
            r_state   <= S_OP;
            r_bit_cnt <= 4'd0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_OP: if (w_mdc_rise) begin
          r_shift <= {r_shift[14:0], w_bit};
          if (r_bit_cnt == 4'd0) begin
            r_bit_cnt <= 4'd1;
          end else if ((w_op == 2'b10) || (w_op == 2'b01)) begin
            r_is_read <= (w_op == 2'b10);
            r_state   <= S_PHYAD;
            r_bit_cnt <= 4'd0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_PHYAD: if (w_mdc_rise) begin
          r_shift <= {r_shift[14:0], w_bit};
          if (r_bit_cnt == 4'd4) begin
            r_match   <= w_match_now;
            r_state   <= S_REGAD;
            r_bit_cnt <= 4'd0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_REGAD: if (w_mdc_rise) begin
          r_shift <= {r_shift[14:0], w_bit};
          if (r_bit_cnt == 4'd4) begin
            r_addr    <= w_field;
            r_re      <= r_is_read & r_match;
            r_state   <= S_TA;
            r_bit_cnt <= 4'd0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_TA: if (w_mdc_rise) begin
          if (r_bit_cnt == 4'd0) begin
            // First turnaround edge: take the line low only if the frame is a read addressed to this PHY.
            r_oen     <= r_is_read & r_match;
            r_mdo     <= 1'b0;
            r_bit_cnt <= 4'd1;
          end else if (r_is_read) begin
            r_mdo     <= r_rdata[15] & r_match;
            r_shift   <= {r_rdata[14:0], 1'b0};
            r_state   <= S_DATA_R;
            r_bit_cnt <= 4'd0;
          end else begin
            r_state   <= S_DATA_W;
            r_bit_cnt <= 4'd0;
          end
        end
        S_DATA_W: if (w_mdc_rise) begin
          r_shift <= {r_shift[14:0], w_bit};
          if (r_bit_cnt == 4'd15) begin
            if (r_match) begin
              r_wdata <= {r_shift[14:0], w_bit};
              r_we    <= 1'b1;
            end
            r_state <= S_DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_DATA_R: if (w_mdc_rise) begin
          if (r_bit_cnt == 4'd15) begin
            r_oen   <= 1'b0;
            r_mdo   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_mdo     <= r_shift[15] & r_match;
            r_shift   <= {r_shift[14:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_pre_cnt <= 6'd0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_oen   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_slave_responder.sv
// tb_mdio_slave_responder: drives Clause 22 frames into two responders.
// Instance a uses the default parameters. Instance b has PREAMBLE_LEN=0 and BCAST_EN=1.
module tb_mdio_slave_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        master_out = 1'b1;
  logic [1:0]  pad, mdo, oen, we, re, busy;
  logic [4:0]  addr [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic [15:0] mem [32];

  int n_cmp = 0, n_bad = 0;
  int we_tot[2], re_tot[2], oen_tot[2], busy_tot[2], both_tot;
  int snap_we[2], snap_re[2], snap_oen[2], snap_busy[2], snap_both;
  logic [4:0]  last_waddr[2], last_raddr[2];
  logic [15:0] last_wdata[2];
  logic [16:0] rd_bits[2];
  logic [17:0] rd_oen[2];
  logic        aborted;

  typedef struct {
    int         pre;
    logic [1:0] st;
    logic [1:0] op;
    logic [4:0] phy;
    logic [4:0] regad;
    logic [15:0] data;
    int         exp_a;    // 0 none, 1 write strobe, 2 read strobe, 3 not checked
    int         exp_b;
    int         busy_a;   // 1 if instance a should enter a frame at all
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  assign pad[0] = oen[0] ? mdo[0] : master_out;
  assign pad[1] = oen[1] ? mdo[1] : master_out;

  mdio_slave_responder u_a (
    .CLK_I(clk), .RSTBP_I(rst), .MGMT_MDC_I(mdc), .MGMT_MDI_I(pad[0]),
    .MGMT_MDO_O(mdo[0]), .MGMT_MDOEN_O(oen[0]), .REG_ADDR_O(addr[0]),
    .REG_WDATA_O(wdata[0]), .REG_WE_O(we[0]), .REG_RE_O(re[0]),
    .REG_RDATA_I(rdata[0]), .BUSY_O(busy[0]));

  mdio_slave_responder #(.PHY_ADDR(5'd18), .PREAMBLE_LEN(0), .BCAST_EN(1'b1)) u_b (
    .CLK_I(clk), .RSTBP_I(rst), .MGMT_MDC_I(mdc), .MGMT_MDI_I(pad[1]),
    .MGMT_MDO_O(mdo[1]), .MGMT_MDOEN_O(oen[1]), .REG_ADDR_O(addr[1]),
    .REG_WDATA_O(wdata[1]), .REG_WE_O(we[1]), .REG_RE_O(re[1]),
    .REG_RDATA_I(rdata[1]), .BUSY_O(busy[1]));

  // Register file stub: data is presented one cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) if (re[i]) rdata[i] <= mem[addr[i]];
  end

  // Output monitor: cumulative strobe, drive and busy counts, plus the last strobe payloads.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        we_tot[i] <= we_tot[i] + 1;
        last_waddr[i] <= addr[i];
        last_wdata[i] <= wdata[i];
      end
      if (re[i]) begin
        re_tot[i] <= re_tot[i] + 1;
        last_raddr[i] <= addr[i];
      end
      if (oen[i]) oen_tot[i] <= oen_tot[i] + 1;
      if (busy[i]) busy_tot[i] <= busy_tot[i] + 1;
      if (we[i] && re[i]) both_tot <= both_tot + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < 2; i++) begin
      snap_we[i] = we_tot[i]; snap_re[i] = re_tot[i];
      snap_oen[i] = oen_tot[i]; snap_busy[i] = busy_tot[i];
    end
    snap_both = both_tot;
  endtask

  task automatic do_reset();
    mdc = 1'b0; master_out = 1'b1; rst = 1'b1;
    #50; rst = 1'b0; #50;
  endtask

  // One MDC period. MDIO changes while MDC is low. Pads are sampled just before the rising edge.
  task automatic bit_cycle(input logic b, input int k);
    mdc = 1'b0; master_out = b; #40;
    if (k >= 0) begin
      for (int i = 0; i < 2; i++) begin
        rd_oen[i][k] = oen[i];
        if (k >= 1) rd_bits[i][17-k] = pad[i];
      end
    end
    mdc = 1'b1; #40;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] data, input int abort_k, output logic ab);
    ab = 1'b0;
    rd_oen[0] = 18'd0; rd_oen[1] = 18'd0; rd_bits[0] = 17'd0; rd_bits[1] = 17'd0;
    for (int i = 0; i < pre; i++) bit_cycle(1'b1, -1);
    bit_cycle(st[1], -1); bit_cycle(st[0], -1);
    bit_cycle(op[1], -1); bit_cycle(op[0], -1);
    for (int i = 4; i >= 0; i--) bit_cycle(phy[i], -1);
    for (int i = 4; i >= 0; i--) bit_cycle(regad[i], -1);
    if (op == 2'b10) begin
      for (int k = 0; k < 18 && !ab; k++) begin
        if (k == abort_k) begin
          rst = 1'b1; #1;
          chk("abort_oen_a", 32'(oen[0]), 32'd0);
          chk("abort_oen_b", 32'(oen[1]), 32'd0);
          ab = 1'b1;
        end else begin
          bit_cycle(1'b1, k);
        end
      end
    end else begin
      bit_cycle(1'b1, -1); bit_cycle(1'b0, -1);
      for (int i = 15; i >= 0; i--) bit_cycle(data[i], -1);
    end
    if (!ab) begin master_out = 1'b1; #160; end
  endtask

  task automatic check_frame(input int i, input int exp_code, input logic [4:0] regad,
                             input logic [15:0] data);
    string nm;
    nm = (i == 0) ? "a" : "b";
    if (exp_code != 3) begin
      chk($sformatf("%s_we_cnt", nm), 32'(we_tot[i] - snap_we[i]), (exp_code == 1) ? 32'd1 : 32'd0);
      chk($sformatf("%s_re_cnt", nm), 32'(re_tot[i] - snap_re[i]), (exp_code == 2) ? 32'd1 : 32'd0);
      chk($sformatf("%s_busy_end", nm), 32'(busy[i]), 32'd0);
      chk($sformatf("%s_oen_end", nm), 32'(oen[i]), 32'd0);
      if (exp_code == 1) begin
        chk($sformatf("%s_waddr", nm), 32'(last_waddr[i]), 32'(regad));
        chk($sformatf("%s_wdata", nm), 32'(last_wdata[i]), 32'(data));
      end
      if (exp_code == 2) begin
        chk($sformatf("%s_raddr", nm), 32'(last_raddr[i]), 32'(regad));
        chk($sformatf("%s_oen_seq", nm), 32'(rd_oen[i]), 32'h3FFFE);
        chk($sformatf("%s_rd_bits", nm), 32'(rd_bits[i]), 32'({1'b0, data}));
      end else begin
        chk($sformatf("%s_no_drive", nm), 32'(oen_tot[i] - snap_oen[i]), 32'd0);
      end
    end
    chk($sformatf("%s_no_dual", nm), 32'(both_tot - snap_both), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [4:0]  r_phy, r_reg;
    logic [15:0] r_data;
    int          r_pre, sel, ea, eb;

    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      we_tot[i] = 0; re_tot[i] = 0; oen_tot[i] = 0; busy_tot[i] = 0;
    end
    both_tot = 0;

    tbl[0]  = '{32, 2'b01, 2'b01, 5'd18, 5'h04, 16'hA5C3, 1, 1, 1};
    tbl[1]  = '{32, 2'b01, 2'b10, 5'd18, 5'h02, 16'h0141, 2, 2, 1};
    tbl[2]  = '{32, 2'b01, 2'b10, 5'd5,  5'h02, 16'h0141, 0, 0, 1};
    tbl[3]  = '{31, 2'b01, 2'b01, 5'd18, 5'h04, 16'h1234, 0, 1, 0};
    tbl[4]  = '{32, 2'b01, 2'b11, 5'd18, 5'h04, 16'h5555, 0, 3, 1};
    tbl[5]  = '{32, 2'b01, 2'b00, 5'd18, 5'h04, 16'h5555, 0, 3, 1};
    tbl[6]  = '{32, 2'b00, 2'b01, 5'd18, 5'h04, 16'h5555, 0, 3, 1};
    tbl[7]  = '{32, 2'b01, 2'b01, 5'd0,  5'h06, 16'hBEEF, 0, 1, 1};
    tbl[8]  = '{32, 2'b01, 2'b10, 5'd0,  5'h06, 16'h7E57, 0, 0, 1};
    tbl[9]  = '{32, 2'b01, 2'b01, 5'd31, 5'h1F, 16'hFFFF, 0, 0, 1};
    tbl[10] = '{40, 2'b01, 2'b10, 5'd18, 5'h1F, 16'hFFFF, 2, 2, 1};
    tbl[11] = '{32, 2'b01, 2'b10, 5'd18, 5'h00, 16'h0000, 2, 2, 1};

    // Reset state
    #37;
    chk("rst_oen", 32'(oen), 32'd0);
    chk("rst_we_re", 32'({we, re}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'({addr[0], addr[1]}), 32'd0);
    chk("rst_wdata", 32'({wdata[0], wdata[1]}), 32'd0);
    do_reset();

    // Directed vector table
    for (int t = 0; t < 12; t++) begin
      do_reset();
      if (tbl[t].op == 2'b10) mem[tbl[t].regad] = tbl[t].data;
      take_snap();
      send_frame(tbl[t].pre, tbl[t].st, tbl[t].op, tbl[t].phy, tbl[t].regad,
                 tbl[t].data, -1, aborted);
      check_frame(0, tbl[t].exp_a, tbl[t].regad, tbl[t].data);
      check_frame(1, tbl[t].exp_b, tbl[t].regad, tbl[t].data);
      chk($sformatf("a_busy_seen_%0d", t), 32'((busy_tot[0] - snap_busy[0]) > 0), 32'(tbl[t].busy_a));
    end

    // Mismatched read followed by an accepted write, with no reset between them
    do_reset();
    take_snap();
    send_frame(32, 2'b01, 2'b10, 5'd5, 5'h02, 16'h0000, -1, aborted);
    chk("mm_busy_seen", 32'((busy_tot[0] - snap_busy[0]) > 0), 32'd1);
    check_frame(0, 0, 5'h02, 16'h0000);
    take_snap();
    send_frame(32, 2'b01, 2'b01, 5'd18, 5'h0A, 16'h3C3C, -1, aborted);
    check_frame(0, 1, 5'h0A, 16'h3C3C);

    // Back-to-back frames with no preamble: only the PREAMBLE_LEN=0 instance accepts them
    do_reset();
    take_snap();
    send_frame(0, 2'b01, 2'b01, 5'd18, 5'h03, 16'h1234, -1, aborted);
    send_frame(0, 2'b01, 2'b01, 5'd18, 5'h07, 16'h8765, -1, aborted);
    chk("b2b_b_we", 32'(we_tot[1] - snap_we[1]), 32'd2);
    chk("b2b_b_addr", 32'(last_waddr[1]), 32'h07);
    chk("b2b_b_wdata", 32'(last_wdata[1]), 32'h8765);
    chk("b2b_a_we", 32'(we_tot[0] - snap_we[0]), 32'd0);

    // Reset asserted while data bit 8 of a read is on the line
    do_reset();
    mem[2] = 16'h0141;
    send_frame(32, 2'b01, 2'b10, 5'd18, 5'h02, 16'h0000, 9, aborted);
    chk("abort_taken", 32'(aborted), 32'd1);
    take_snap();
    #100;
    mdc = 1'b0; master_out = 1'b1; #20;
    rst = 1'b0; #50;
    chk("abort_a_strobes", 32'((we_tot[0] - snap_we[0]) + (re_tot[0] - snap_re[0])), 32'd0);
    chk("abort_b_strobes", 32'((we_tot[1] - snap_we[1]) + (re_tot[1] - snap_re[1])), 32'd0);
    mem[9] = 16'hC0DE;
    take_snap();
    send_frame(32, 2'b01, 2'b10, 5'd18, 5'h09, 16'h0000, -1, aborted);
    check_frame(0, 2, 5'h09, 16'hC0DE);
    check_frame(1, 2, 5'h09, 16'hC0DE);

    // Randomized frames against the reference model
    do_reset();
    for (int r = 0; r < 30; r++) begin
      r_op = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
      sel = $urandom_range(0, 9);
      r_phy = (sel < 5) ? 5'd18 : (sel < 7) ? 5'd0 : 5'($urandom);
      r_reg = 5'($urandom);
      r_data = 16'($urandom);
      r_pre = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(32, 40);
      // Model: instance a needs >= 32 preamble ones and an exact address match.
      // Instance b needs no preamble and also takes writes to address 0.
      ea = (r_pre >= 32 && r_phy == 5'd18) ? ((r_op == 2'b01) ? 1 : 2) : 0;
      eb = (r_phy == 5'd18 || (r_op == 2'b01 && r_phy == 5'd0)) ? ((r_op == 2'b01) ? 1 : 2) : 0;
      take_snap();
      send_frame(r_pre, 2'b01, r_op, r_phy, r_reg, r_data, -1, aborted);
      check_frame(0, ea, r_reg, (r_op == 2'b10) ? mem[r_reg] : r_data);
      check_frame(1, eb, r_reg, (r_op == 2'b10) ? mem[r_reg] : r_data);
      chk($sformatf("rnd_a_busy_seen_%0d", r), 32'((busy_tot[0] - snap_busy[0]) > 0),
          (r_pre >= 32) ? 32'd1 : 32'd0);
      if (r_pre < 32) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
